// File: rtl/gcd_engine.sv
// Subtractive GCD engine: IDLE -> CALC (one subtract per cycle) -> DONE.
// Optional iteration counter output is enabled by defining GCD_ITER_CNT_EN.
module gcd_engine #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] result,
`ifdef GCD_ITER_CNT_EN
  output logic [CNT_W-1:0] iter_count,
`endif
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             finish;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    accept   = 1'b0;
    finish   = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          accept  = 1'b1;
          a_d     = a_in;
          b_d     = b_in;
          state_d = StCalc;
        end
      end
      StCalc: begin
        // Rule order matters: zero checks first so gcd(x,0) resolves in one cycle.
        if (a_q == '0) begin
          result_d = b_q;
          finish   = 1'b1;
        end else if (b_q == '0) begin
          result_d = a_q;
          finish   = 1'b1;
        end else if (a_q == b_q) begin
          result_d = a_q;
          finish   = 1'b1;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
        if (finish) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StCalc);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

`ifdef GCD_ITER_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [CNT_W-1:0] cnt_inc;

  // Saturating increment; iter_count latches the count including the final CALC cycle.
  always_comb begin
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    if (accept) begin
      cnt_d = '0;
    end else if (state_q == StCalc) begin
      cnt_d = cnt_inc;
    end
    if (finish) begin
      iter_d = cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      iter_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      iter_q <= iter_d;
    end
  end

  assign iter_count = iter_q;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: driver pushes expected (result, CALC cycles),
// a negedge monitor pops and checks on each rising done.
module tb_gcd_engine;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 17;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
`ifdef GCD_ITER_CNT_EN
  logic [CNT_W-1:0] iter_count;
`endif

  gcd_engine #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .result    (result),
`ifdef GCD_ITER_CNT_EN
    .iter_count(iter_count),
`endif
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    int               n;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  int               busy_cnt = 0;
  logic             prev_done = 1'b0;
  logic [WIDTH-1:0] prev_res = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) begin
        busy_cnt++;
        check("result_stable_while_busy", 64'(result), 64'(prev_res));
      end
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got result %0d expected no completion", result);
        end else begin
          e = exp_q.pop_front();
          check("result", 64'(result), 64'(e.res));
          check("calc_cycles", 64'(busy_cnt), 64'(e.n));
`ifdef GCD_ITER_CNT_EN
          check("iter_count", 64'(iter_count), 64'(e.n));
`endif
        end
        busy_cnt = 0;
      end
    end
    prev_done = done;
    prev_res  = result;
  end

  // Driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] res, input int n, input bit push);
    exp_t e;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    if (push) begin
      e.res = res;
      e.n   = n;
      exp_q.push_back(e);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got done=0 expected done=1 within %0d cycles", budget);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    tick();
    tick();
    check("reset_result", 64'(result), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
`ifdef GCD_ITER_CNT_EN
    check("reset_iter_count", 64'(iter_count), 64'd0);
`endif
    rst = 1'b0;

    // Start on the first edge after reset release.
    issue(16'd48048, 16'd15015, 16'd3003, 8, 1'b1);
    check("busy_after_start", 64'(busy), 64'd1);
    check("done_after_start", 64'(done), 64'd0);
    wait_done(50);
    check("busy_in_done", 64'(busy), 64'd0);
    tick();

    issue(16'd12, 16'd18, 16'd6, 3, 1'b1);
    wait_done(50);
    tick();
    issue(16'd18, 16'd12, 16'd6, 3, 1'b1);
    wait_done(50);
    tick();
    issue(16'd0, 16'd25, 16'd25, 1, 1'b1);
    wait_done(50);
    tick();
    issue(16'd40, 16'd0, 16'd40, 1, 1'b1);
    wait_done(50);
    tick();
    issue(16'd0, 16'd0, 16'd0, 1, 1'b1);
    wait_done(50);
    repeat (5) tick();
    check("done_held", 64'(done), 64'd1);
    check("result_held", 64'(result), 64'd0);

    // Start during CALC must be ignored.
    issue(16'd65535, 16'd1, 16'd1, 65535, 1'b1);
    repeat (5) tick();
    a_in  = 16'd6;
    b_in  = 16'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_ignored_start", 64'(busy), 64'd1);
    wait_done(70000);
    tick();

    // Reset on the 4th CALC cycle aborts with no completion.
    issue(16'd48048, 16'd15015, 16'd0, 0, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", 64'(result), 64'd0);
`ifdef GCD_ITER_CNT_EN
    check("abort_iter_count", 64'(iter_count), 64'd0);
`endif
    issue(16'd9, 16'd6, 16'd3, 3, 1'b1);
    wait_done(50);

    // Back-to-back: start issued while in DONE.
    issue(16'd21, 16'd14, 16'd7, 3, 1'b1);
    check("b2b_done_drops", 64'(done), 64'd0);
    check("b2b_busy", 64'(busy), 64'd1);
    wait_done(50);
    repeat (3) tick();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gcd_engine.md
GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand and result width in bits (legal range 4..32).
REQ-002 SHALL provide parameter CNT_W, default WIDTH+1, width of the iteration counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port start, input, 1, request to begin a computation.
REQ-006 SHALL have port a_in, input, WIDTH, first operand, unsigned.
REQ-007 SHALL have port b_in, input, WIDTH, second operand, unsigned.
REQ-008 SHALL have port result, output, WIDTH, the GCD of the last completed operand pair.
REQ-009 SHALL have port busy, output, 1, high while a computation is in progress.
REQ-010 SHALL have port done, output, 1, high while result is valid.
REQ-011 SHALL have port iter_count, output, CNT_W, CALC cycles used by the last computation; present only when GCD_ITER_CNT_EN is defined.

Function
REQ-012 SHALL implement the FSM states IDLE, CALC and DONE, with all outputs driven from registers.
REQ-013 In IDLE or DONE, start=1 at a clock edge SHALL capture a_in and b_in into internal registers A and B, clear done, and enter CALC.
REQ-014 The operands SHALL be loaded together in one cycle; no sequential operand loading is required.
REQ-015 Each CALC cycle SHALL apply the first matching rule, in this order:
 - A==0: result<=B, go to DONE.
 - B==0: result<=A, go to DONE.
 - A==B: result<=A, go to DONE.
 - A>B: A<=A-B, stay in CALC.
 - otherwise: B<=B-A, stay in CALC.
REQ-016 Subtraction SHALL be unsigned WIDTH-bit, and no underflow SHALL be possible under REQ-015.
REQ-017 Zero-operand cases SHALL resolve as gcd(x,0)=x and gcd(0,0)=0, each in one CALC cycle.
REQ-018 busy SHALL be 1 exactly in CALC, and done SHALL be 1 exactly in DONE.
REQ-019 DONE SHALL hold result and done=1 indefinitely until the next start or rst.
REQ-020 start while in CALC SHALL be ignored; a_in and b_in SHALL not be sampled and the computation SHALL be unaffected.
REQ-021 result SHALL change only on entry to DONE or on rst, never while busy=1.
REQ-022 Latency from the start edge to done=1 SHALL equal the number of CALC cycles, N, where N = subtraction steps + 1.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE with A=0, B=0, result=0, busy=0, done=0, and iter_count=0 when present.
REQ-024 rst SHALL take priority over start and over any CALC update on the same edge.
REQ-025 rst during CALC SHALL abort the computation with no done pulse; the next start SHALL behave as if from power-up.
REQ-026 After rst is released, the block SHALL accept start on the first following edge.

Configuration
REQ-027 Macro GCD_ITER_CNT_EN defined SHALL enable iter_count and its counter logic.
REQ-028 With GCD_ITER_CNT_EN defined:
 - the counter SHALL clear on start acceptance;
 - it SHALL increment once per CALC cycle;
 - it SHALL saturate at 2^CNT_W-1;
 - iter_count SHALL be updated on entry to DONE and held until the next entry to DONE or rst.
REQ-029 With GCD_ITER_CNT_EN undefined, the iter_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 WIDTH=16, a_in=48048, b_in=15015, start pulse -> busy for 8 cycles, then done=1, result=3003, iter_count=8.
REQ-031 a_in=12, b_in=18 -> result=6 after 3 CALC cycles, iter_count=3; swapping the operands to (18,12) -> result=6, iter_count=3.
REQ-032 Zero operands:
 - (0,25) -> result=25 after 1 CALC cycle;
 - (40,0) -> result=40;
 - (0,0) -> result=0, done=1, iter_count=1.
REQ-033 Start (65535,1), pulse start with (6,4) mid-CALC -> second start ignored; result=1, iter_count=65535 (CNT_W=17, no saturation).
REQ-034 Start (48048,15015), assert rst on 4th CALC cycle -> next edge busy=0, done=0, result=0; fresh start (9,6) -> result=3.
REQ-035 Back-to-back runs: start asserted in the DONE cycle with (21,14) -> re-enters CALC immediately, done drops, result=7 after 3 CALC cycles.
